uob_output_arbiter: RTL and testbench
=====================================

Name: uob_output_arbiter

Overview:
- Downstream consumer of the per-unit output buffers (UOBs).
- Round-robin arbitrates among N_UNITS buffers and issues the one-cycle read strobe to the winner.
- Captures the unit's narrow serial burst (header word, then OUT_N_WORDS data words) from a shared OR-bus.
- Repacks the burst into 16-bit words, prefixed by a unit-tag word, and writes them into the downstream output FIFO.

Parameters:
- N_UNITS, 4, number of UOBs served.
- N_UNITS_MSB, `MSB(N_UNITS-1), width-1 of the unit index.
- OUT_WIDTH, `UNIT_OUTPUT_WIDTH (4), width of the unit serial bus.
- OUT_N_WORDS, 48, data words per unit packet, excluding the header.
- PKT_OUT_WORDS, OUT_N_WORDS*OUT_WIDTH/16 (12), 16-bit data words per packet.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- unit_empty  in  N_UNITS  per-unit empty; 0 means the unit has a packet ready.
- unit_rd_en  out  N_UNITS  one-hot, one-cycle read strobe to the granted unit.
- unit_dout  in  OUT_WIDTH  OR of all units' dout. Idle units drive 0.
- out_afull  in  1  downstream FIFO has fewer than PKT_OUT_WORDS+1 free entries.
- out_dout  out  16  word to the downstream FIFO.
- out_wr_en  out  1  write strobe for out_dout.
- err_header  out  1  sticky; set when a header word is not all-ones.
- idle  out  1  high in IDLE state.

Behaviour:
- Async reset: state=IDLE; unit_rd_en=0, out_wr_en=0, out_dout=0, err_header=0; rr pointer=N_UNITS-1; pack register and counters =0. Reset mid-packet abandons the packet; no partial word is written after reset.
- Arbitration: in IDLE, when some unit_empty[k]==0 and out_afull==0, grant the first such k searching from rr+1 upward, wrapping modulo N_UNITS. Then:
  - rr<=k; unit_rd_en[k]<=1 for exactly one cycle.
  - out_dout<={zero-extend k}; out_wr_en<=1 (tag word).
  - state<=WAIT.
- out_afull is sampled only in IDLE. Once granted, a packet is never stalled; the unit cannot be paused.
- Unit timing, relative to the edge E1 at which unit_rd_en is first seen high:
  - header (all ones) appears on unit_dout after E1;
  - data words follow on the next OUT_N_WORDS consecutive cycles;
  - then the bus returns to 0.
- States:
  - WAIT (1 cycle): rd_en<=0 -> HDR.
  - HDR: sample unit_dout. If it is not all-ones, set err_header and still continue. Clear word counter -> DATA.
  - DATA: sample one word per cycle into a 16-bit shift register, first word into the LSBs (word i of a group at bits [i*OUT_WIDTH +: OUT_WIDTH]).
    - Every 16/OUT_WIDTH words: out_dout<=packed, out_wr_en<=1 for 1 cycle.
    - After word OUT_N_WORDS-1 -> GAP.
  - GAP (2 cycles): lets the unit pass RD_END and settle empty. Then IDLE.
- A packet produces exactly 1+PKT_OUT_WORDS writes. From grant to the last write: 2+OUT_N_WORDS cycles.
- Earliest re-grant: GAP then IDLE. Minimum grant-to-grant spacing is OUT_N_WORDS+5 cycles.
- Simultaneous requests are served in rotation. A unit re-requesting immediately after service waits behind every other requester.
- unit_empty of non-granted units is ignored outside IDLE.
- OUT_N_WORDS*OUT_WIDTH must be a multiple of 16; the bench and synthesis check this with an elaboration-time assertion.

Decomposition:
- md5.vh supplies `MSB and `UNIT_OUTPUT_WIDTH. Add `UOB_HEADER (all-ones of OUT_WIDTH) there.
- State encodings are local parameters.
- One sub-module: rr_arbiter (N_UNITS requests, rr pointer in, one-hot grant plus index out; combinational).

Test Plan:
- Single unit 0 ready, out_afull=0 → unit_rd_en=0001 for 1 cycle; 13 writes: tag 0x0000, then 12 packed words. Data nibbles 0..F repeating → first data word 0x3210.
- Units 1 and 3 ready simultaneously after reset → grant order 1, 3, 1, 3 while both stay ready. Tag words 0x0001, 0x0003 alternate. Grant spacing ≥53 cycles.
- out_afull=1 with unit 2 ready → no rd_en and no writes for 20 cycles. Release afull → grant within 1 cycle.
- Header nibble 0xE instead of 0xF → err_header=1 and stays set; packet still written as 13 words.
- rst asserted at DATA word 20 → all outputs 0 immediately; no further out_wr_en. After release, the next ready unit is granted normally.
- All 4 units ready continuously for 8 packets → each unit granted exactly twice; 104 writes total.

Source files
------------

// File: rtl/uob_output_arbiter_pkg.sv
// Shared types and constants for the UOB output arbiter: unit bus width,
// packet geometry defaults and the arbiter FSM state encoding.
package uob_output_arbiter_pkg;

   localparam int UNIT_OUTPUT_WIDTH = 4;
   localparam int OUT_N_WORDS_DEF   = 48;
   localparam int OUT_DOUT_W        = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HDR,
      ST_DATA,
      ST_GAP
   } state_e;

   // Index of the most significant bit needed to hold the value v.
   function automatic int msb(input int v);
      return (v < 2) ? 0 : $clog2(v + 1) - 1;
   endfunction

endpackage

// File: rtl/uob_output_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request above the pointer, wrapping,
// returned as a one-hot grant plus its binary index.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   int unsigned k;

   // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      k     = 0;
      for (int off = 1; off <= N; off++) begin
         k = (int'(ptr_i) + off) % N;
         if (!any_o && req_i[k]) begin
            any_o    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/uob_output_arbiter.sv
// Serves the per-unit output buffers in rotation, captures each unit's serial
// burst from the shared OR-bus and writes it downstream as tagged 16-bit words.
module uob_output_arbiter
   import uob_output_arbiter_pkg::*;
#(
   parameter int N_UNITS       = 4,
   parameter int N_UNITS_MSB   = msb(N_UNITS - 1),
   parameter int OUT_WIDTH     = UNIT_OUTPUT_WIDTH,
   parameter int OUT_N_WORDS   = OUT_N_WORDS_DEF,
   parameter int PKT_OUT_WORDS = OUT_N_WORDS * OUT_WIDTH / OUT_DOUT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_UNITS-1:0]    unit_empty,
   output logic [N_UNITS-1:0]    unit_rd_en,
   input  logic [OUT_WIDTH-1:0]  unit_dout,
   input  logic                  out_afull,
   output logic [OUT_DOUT_W-1:0] out_dout,
   output logic                  out_wr_en,
   output logic                  err_header,
   output logic                  idle
);

   localparam int IDX_W = N_UNITS_MSB + 1;
   localparam int WPG   = OUT_DOUT_W / OUT_WIDTH;
   localparam int CNT_W = (OUT_N_WORDS > 2) ? $clog2(OUT_N_WORDS) : 1;
   localparam int GRP_W = (WPG > 1) ? $clog2(WPG) : 1;

   localparam logic [OUT_WIDTH-1:0] UOB_HEADER = '1;
   localparam logic [CNT_W-1:0]     LAST_WORD  = CNT_W'(OUT_N_WORDS - 1);
   localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(1);
   localparam logic [GRP_W-1:0]     LAST_GRP   = GRP_W'(WPG - 1);

   if ((PKT_OUT_WORDS * OUT_DOUT_W != OUT_N_WORDS * OUT_WIDTH) ||
       (OUT_DOUT_W % OUT_WIDTH != 0)) begin : g_bad_cfg
      $error("uob_output_arbiter: burst does not pack into whole 16-bit words");
   end

   state_e                  state_q;
   logic [IDX_W-1:0]        rr_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [GRP_W-1:0]        grp_q;
   logic [OUT_DOUT_W-1:0]   pack_q;
   logic [OUT_DOUT_W-1:0]   pack_d;
   logic [N_UNITS-1:0]      gnt_onehot;
   logic [IDX_W-1:0]        gnt_idx;
   logic                    gnt_any;

   rr_arbiter #(
      .N     (N_UNITS),
      .IDX_W (IDX_W)
   ) u_rr (
      .req_i (~unit_empty),
      .ptr_i (rr_q),
      .gnt_o (gnt_onehot),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   // Newest bus word enters at the top so the first word of a group ends in the LSBs.
   assign pack_d = (pack_q >> OUT_WIDTH) |
                   (OUT_DOUT_W'(unit_dout) << (OUT_DOUT_W - OUT_WIDTH));

   assign idle = (state_q == ST_IDLE);

   // NOTE: all state and registered outputs use non-blocking assignments; strobes default low each cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_q       <= IDX_W'(N_UNITS - 1);
         cnt_q      <= '0;
         grp_q      <= '0;
         pack_q     <= '0;
         unit_rd_en <= '0;
         out_dout   <= '0;
         out_wr_en  <= 1'b0;
         err_header <= 1'b0;
      end else begin
         unit_rd_en <= '0;
         out_wr_en  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (gnt_any && !out_afull) begin
                  rr_q       <= gnt_idx;
                  unit_rd_en <= gnt_onehot;
                  out_dout   <= OUT_DOUT_W'(gnt_idx);
                  out_wr_en  <= 1'b1;
                  state_q    <= ST_WAIT;
               end
            end
            ST_WAIT: state_q <= ST_HDR;
            ST_HDR: begin
               // A bad header is flagged but the burst is still consumed, keeping the bus in step.
               if (unit_dout != UOB_HEADER) err_header <= 1'b1;
               cnt_q   <= '0;
               grp_q   <= '0;
               state_q <= ST_DATA;
            end
            ST_DATA: begin
               pack_q <= pack_d;
               if (grp_q == LAST_GRP) begin
                  out_dout  <= pack_d;
                  out_wr_en <= 1'b1;
                  grp_q     <= '0;
               end else begin
                  grp_q <= grp_q + 1'b1;
               end
               if (cnt_q == LAST_WORD) begin
                  cnt_q   <= '0;
                  state_q <= ST_GAP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uob_output_arbiter.sv
// Scoreboard bench for uob_output_arbiter: behavioural unit models on the OR-bus,
// expected grants/words queued by the stimulus, popped by an independent monitor.
module tb_uob_output_arbiter;

   localparam int NU = 4;
   localparam int NW = 48;
   localparam int SPACING = NW + 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [NU-1:0] unit_empty;
   logic [NU-1:0] unit_rd_en;
   logic [3:0]    unit_dout;
   logic          out_afull;
   logic [15:0]   out_dout;
   logic          out_wr_en;
   logic          err_header;
   logic          idle;

   uob_output_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .unit_empty (unit_empty),
      .unit_rd_en (unit_rd_en),
      .unit_dout  (unit_dout),
      .out_afull  (out_afull),
      .out_dout   (out_dout),
      .out_wr_en  (out_wr_en),
      .err_header (err_header),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int n_grants = 0;
   int n_writes = 0;
   int last_gnt_cyc = -1;
   int last_wr_cyc = -1;
   int gcnt[NU] = '{default: 0};
   bit spacing_on = 1'b0;

   int         req_total[NU];
   int         served[NU];
   int         phase[NU];
   int         pseed[NU];
   logic [3:0] hdr[NU];
   logic [3:0] drv[NU];

   logic [3:0]  exp_g[$];
   logic [15:0] exp_w[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] seed_of(input int u, input int p);
      return 4'((u * 5 + p * 3) % 16);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      unit_empty = '0;
      for (int u = 0; u < NU; u++) unit_empty[u] = (served[u] >= req_total[u]);
   end

   // Unit model: header on the cycle after rd_en is seen, then NW data nibbles, then 0.
   always @(negedge clk) begin
      for (int u = 0; u < NU; u++) begin
         if (rst) begin
            phase[u]  = -1;
            served[u] = 0;
            drv[u]    = 4'h0;
         end else begin
            if (phase[u] >= 0) begin
               phase[u]++;
               if (phase[u] == 1) drv[u] = hdr[u];
               else if (phase[u] <= NW + 1) drv[u] = 4'(pseed[u] + phase[u] - 2);
               else begin
                  drv[u]   = 4'h0;
                  phase[u] = -1;
               end
            end
            if (unit_rd_en[u]) begin
               phase[u] = 0;
               pseed[u] = int'(seed_of(u, served[u]));
               served[u]++;
            end
         end
      end
      unit_dout = drv[0] | drv[1] | drv[2] | drv[3];
   end

   // Monitor: pops expectations whenever the DUT strobes a grant or a write.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         last_gnt_cyc = -1;
      end else begin
         if (unit_rd_en != '0) begin
            if (exp_g.size() == 0) check("grant_unexpected", 32'(unit_rd_en), 32'd0);
            else check("grant", 32'(unit_rd_en), 32'(exp_g.pop_front()));
            check("tag_with_grant", 32'(out_wr_en), 32'd1);
            if (spacing_on && last_gnt_cyc >= 0)
               check("grant_spacing", 32'(cyc - last_gnt_cyc), 32'(SPACING));
            last_gnt_cyc = cyc;
            n_grants++;
            for (int u = 0; u < NU; u++) if (unit_rd_en[u]) gcnt[u]++;
         end
         if (out_wr_en) begin
            if (exp_w.size() == 0) check("write_unexpected", 32'(out_wr_en), 32'd0);
            else check("out_dout", 32'(out_dout), 32'(exp_w.pop_front()));
            n_writes++;
            last_wr_cyc = cyc;
         end
      end
   end

   task automatic push_pkt(input int u, input int p);
      logic [3:0]  s;
      logic [15:0] w;
      s = seed_of(u, p);
      exp_g.push_back(4'(1 << u));
      exp_w.push_back(16'(u));
      for (int j = 0; j < 12; j++) begin
         w = '0;
         for (int k = 0; k < 4; k++) w[4*k +: 4] = 4'(s + 4 * j + k);
         exp_w.push_back(w);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst        = 1'b1;
      out_afull  = 1'b0;
      spacing_on = 1'b0;
      for (int u = 0; u < NU; u++) begin
         req_total[u] = 0;
         hdr[u]       = 4'hF;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_grant(input int n0, input int maxc);
      int c = 0;
      while (n_grants == n0 && c < maxc) begin
         @(negedge clk);
         c++;
      end
      check("grant_timeout", 32'(n_grants > n0), 32'd1);
   endtask

   task automatic wait_drain(input int maxc);
      int c = 0;
      while ((exp_w.size() != 0 || exp_g.size() != 0) && c < maxc) begin
         @(negedge clk);
         c++;
      end
      check("drain_timeout", 32'(exp_w.size() + exp_g.size()), 32'd0);
      repeat (6) @(negedge clk);
   endtask

   initial begin
      int w0, g0, rel;
      int gc0[NU];
      rst       = 1'b1;
      out_afull = 1'b0;
      for (int u = 0; u < NU; u++) begin
         req_total[u] = 0;
         hdr[u]       = 4'hF;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_rd_en", 32'(unit_rd_en), 32'd0);
      check("rst_wr_en", 32'(out_wr_en), 32'd0);
      check("rst_dout", 32'(out_dout), 32'd0);
      check("rst_err", 32'(err_header), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);

      // Single unit 0 packet: tag 0x0000 then 12 words starting 0x3210
      push_pkt(0, 0);
      req_total[0] = 1;
      wait_drain(200);
      check("grant_to_last_write", 32'(last_wr_cyc - last_gnt_cyc), 32'(NW + 2));
      check("idle_after_pkt", 32'(idle), 32'd1);
      check("err_clean_hdr", 32'(err_header), 32'd0);

      // Units 1 and 3 together: 1,3,1,3 with back-to-back spacing
      apply_reset();
      spacing_on = 1'b1;
      push_pkt(1, 0);
      push_pkt(3, 0);
      push_pkt(1, 1);
      push_pkt(3, 1);
      req_total[1] = 2;
      req_total[3] = 2;
      wait_drain(400);

      // out_afull holds off unit 2; afull ignored once granted
      apply_reset();
      out_afull    = 1'b1;
      req_total[2] = 1;
      w0 = n_writes;
      g0 = n_grants;
      repeat (20) @(negedge clk);
      check("afull_no_grant", 32'(n_grants - g0), 32'd0);
      check("afull_no_write", 32'(n_writes - w0), 32'd0);
      check("afull_idle", 32'(idle), 32'd1);
      push_pkt(2, 0);
      out_afull = 1'b0;
      rel = cyc;
      wait_grant(g0, 10);
      check("afull_release_latency", 32'(last_gnt_cyc - rel), 32'd1);
      out_afull = 1'b1;
      wait_drain(200);
      out_afull = 1'b0;

      // Bad header on unit 0: sticky error, packet still complete
      apply_reset();
      hdr[0]       = 4'hE;
      push_pkt(0, 0);
      req_total[0] = 1;
      wait_drain(200);
      check("err_set", 32'(err_header), 32'd1);
      hdr[0]       = 4'hF;
      push_pkt(1, 0);
      req_total[1] = 1;
      wait_drain(200);
      check("err_sticky", 32'(err_header), 32'd1);

      // Reset during DATA word 20 of a unit 1 packet
      apply_reset();
      g0 = n_grants;
      push_pkt(1, 0);
      req_total[1] = 1;
      wait_grant(g0, 10);
      begin
         int c = 0;
         while (cyc < last_gnt_cyc + 23 && c < 60) begin
            @(negedge clk);
            c++;
         end
      end
      rst = 1'b1;
      for (int u = 0; u < NU; u++) req_total[u] = 0;
      #1;
      check("midrst_pending_words", 32'(exp_w.size()), 32'd7);
      check("midrst_wr_en", 32'(out_wr_en), 32'd0);
      check("midrst_dout", 32'(out_dout), 32'd0);
      check("midrst_rd_en", 32'(unit_rd_en), 32'd0);
      check("midrst_idle", 32'(idle), 32'd1);
      exp_w.delete();
      exp_g.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      w0 = n_writes;
      repeat (60) @(negedge clk);
      check("midrst_no_writes", 32'(n_writes - w0), 32'd0);
      push_pkt(3, 0);
      req_total[3] = 1;
      wait_drain(200);

      // All four units, two packets each
      apply_reset();
      spacing_on = 1'b1;
      w0 = n_writes;
      for (int u = 0; u < NU; u++) gc0[u] = gcnt[u];
      for (int p = 0; p < 2; p++)
         for (int u = 0; u < NU; u++) push_pkt(u, p);
      for (int u = 0; u < NU; u++) req_total[u] = 2;
      wait_drain(1000);
      check("all4_writes", 32'(n_writes - w0), 32'd104);
      for (int u = 0; u < NU; u++) check("all4_grants_per_unit", 32'(gcnt[u] - gc0[u]), 32'd2);
      check("all4_idle", 32'(idle), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
